// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } kp_state_e;

    typedef enum logic [1:0] {
        NONE,
        KEY,
        MULTI
    } scan_res_e;

    // Columns are active-low: a 0 bit is a closed switch in the driven row.
    function automatic logic [2:0] count_closed(input logic [NUM_COLS-1:0] cols_n);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            n = n + {2'b00, ~cols_n[i]};
        end
        return n;
    endfunction

    function automatic logic [1:0] first_closed(input logic [NUM_COLS-1:0] cols_n);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!cols_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// Row drive timing: holds each row low for SCAN_DIV cycles and strobes
// the column sample point and the end of a full four-row scan.
module keypad_row_driver
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic                clk,
    input  logic                rst_ni,
    output logic [NUM_ROWS-1:0] row_sel_o,
    output logic [1:0]          row_idx_o,
    output logic                sample_o,
    output logic                scan_end_o
);

    logic [15:0]         tick_q;
    logic [1:0]          row_idx_q;
    logic [NUM_ROWS-1:0] row_sel_q;
    logic                last_tick;

    assign last_tick = (tick_q == SCAN_DIV - 16'd1);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_q    <= '0;
            row_idx_q <= '0;
            row_sel_q <= 4'b1110;
        end else if (last_tick) begin
            tick_q    <= '0;
            row_idx_q <= row_idx_q + 2'd1;
            row_sel_q <= {row_sel_q[NUM_ROWS-2:0], row_sel_q[NUM_ROWS-1]};
        end else begin
            tick_q    <= tick_q + 16'd1;
        end
    end

    assign row_sel_o  = row_sel_q;
    assign row_idx_o  = row_idx_q;
    assign sample_o   = last_tick;
    assign scan_end_o = last_tick && (row_idx_q == 2'd3);

endmodule

// File: rtl/keypad_scanner_matrix.sv
// 4x4 keypad scanner with whole-scan debounce and a one-entry valid/ack
// output buffer. Define KEYPAD_REPEAT_EN to re-emit a held key periodically.
module keypad_scanner_matrix
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter int          DEBOUNCE_SCANS = 4,
    parameter int          REPEAT_SCANS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_COLS-1:0]   col_in,
    output logic [NUM_ROWS-1:0]   row_sel,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    input  logic                  key_ack,
    output logic                  overrun
);

    // One scan counter serves debounce and, when enabled, auto-repeat; the
    // states that use them never overlap.
    localparam int CNT_MAX  = (REPEAT_SCANS > DEBOUNCE_SCANS) ? REPEAT_SCANS : DEBOUNCE_SCANS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_SCANS);
`endif

    logic [NUM_COLS-1:0]   col_meta_q, col_sync_q;
    logic [1:0]            row_idx;
    logic                  sample, scan_end;
    logic [1:0]            hits_q;
    logic [KEY_CODE_W-1:0] acc_code_q;
    logic [2:0]            hits_tot;
    logic [KEY_CODE_W-1:0] scan_code;
    scan_res_e             scan_res;

    kp_state_e             state_q, state_d;
    logic [KEY_CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic                  emit;
    logic [KEY_CODE_W-1:0] key_code_q;
    logic                  key_valid_q, overrun_q;

    keypad_row_driver #(.SCAN_DIV(SCAN_DIV)) u_row_driver (
        .clk        (clk),
        .rst_ni     (rst),
        .row_sel_o  (row_sel),
        .row_idx_o  (row_idx),
        .sample_o   (sample),
        .scan_end_o (scan_end)
    );

    // Closures accumulate across the four rows; the count saturates at 2.
    assign hits_tot  = {1'b0, hits_q} + count_closed(col_sync_q);
    assign scan_code = (hits_q == 2'd1) ? acc_code_q : {row_idx, first_closed(col_sync_q)};
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        scan_res = NONE;
        if (hits_tot == 3'd1) begin
            scan_res = KEY;
        end else if (hits_tot >= 3'd2) begin
            scan_res = MULTI;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        if (scan_end) begin
            case (state_q)
                IDLE: begin
                    if (scan_res == KEY) begin
                        cand_d = scan_code;
                        if (DEB_LAST == CNT_W'(1)) begin
                            emit    = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (scan_res != KEY) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (scan_code != cand_q) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_W'(1);
                    end else if (cnt_inc == DEB_LAST) begin
                        emit    = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    if (scan_res == NONE) begin
                        if (DEB_LAST == CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = DEB_RELEASE;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (scan_res == KEY && scan_code == cand_q) begin
                        if (cnt_inc == REP_LAST) begin
                            emit  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
`endif
                end
                DEB_RELEASE: begin
                    if (scan_res != NONE) begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end else if (cnt_inc == DEB_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            hits_q      <= '0;
            acc_code_q  <= '0;
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
            if (sample) begin
                acc_code_q <= scan_code;
                if (scan_end) begin
                    hits_q <= '0;
                end else begin
                    hits_q <= (hits_tot >= 3'd2) ? 2'd2 : hits_tot[1:0];
                end
            end
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            overrun_q <= 1'b0;
            if (emit) begin
                if (!key_valid_q || key_ack) begin
                    key_code_q  <= cand_d;
                    key_valid_q <= 1'b1;
                end else begin
                    overrun_q   <= 1'b1;
                end
            end else if (key_ack) begin
                key_valid_q <= 1'b0;
            end
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner_matrix.sv
// Directed bench: SCAN_DIV=4, DEBOUNCE_SCANS=2, one scan = 16 cycles.
module tb_keypad_scanner_matrix;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_sel;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack = 1'b0;
    logic        overrun;
    logic [15:0] pressed = '0;

    int   n_total  = 0;
    int   n_bad    = 0;
    int   ovr_cnt  = 0;
    int   rise_cnt = 0;
    int   ovr_base;
    int   rise_base;
    logic prev_v   = 1'b0;

    keypad_scanner_matrix #(
        .SCAN_DIV       (16'd4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_SCANS   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_sel   (row_sel),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Keypad model: key r*4+c pulls column c low while row r is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_sel[r] && pressed[r*4+c]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (key_valid === 1'b1 && !prev_v) rise_cnt++;
        prev_v = (key_valid === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end else begin
            $display("chk  %s: got %h", tag, obs);
        end
    endtask

    // Leaves the bench at the negedge before the first post-reset edge.
    task automatic do_reset(input logic [15:0] keys);
        rst     = 1'b0;
        key_ack = 1'b0;
        pressed = keys;
        step(3);
        rst     = 1'b1;
        ovr_base  = ovr_cnt;
        rise_base = rise_cnt;
    endtask

    initial begin
        // Reset values and row sequence with no keys.
        step(3);
        check("rst_row_sel", 16'(row_sel), 16'hE);
        check("rst_code", 16'(key_code), 16'h0);
        check("rst_valid", 16'(key_valid), 16'h0);
        check("rst_overrun", 16'(overrun), 16'h0);
        do_reset(16'h0000);
        step(3);
        check("row0_hold", 16'(row_sel), 16'hE);
        step(1);
        check("row1", 16'(row_sel), 16'hD);
        step(4);
        check("row2", 16'(row_sel), 16'hB);
        step(4);
        check("row3", 16'(row_sel), 16'h7);
        step(4);
        check("row_wrap", 16'(row_sel), 16'hE);
        step(32);
        check("idle_valid", 16'(key_valid), 16'h0);

`ifndef KEYPAD_REPEAT_EN
        // Key 9 held from reset: single emission, held until ack.
        do_reset(16'h0200);
        step(31);
        check("k9_before", 16'(key_valid), 16'h0);
        step(1);
        check("k9_valid", 16'(key_valid), 16'h1);
        check("k9_code", 16'(key_code), 16'h9);
        step(48);
        check("k9_hold_valid", 16'(key_valid), 16'h1);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("k9_acked", 16'(key_valid), 16'h0);
        step(95);
        check("k9_no_reemit", 16'(key_valid), 16'h0);
        check("k9_emit_count", 16'(rise_cnt - rise_base), 16'd1);
        check("k9_no_overrun", 16'(ovr_cnt - ovr_base), 16'd0);
`else
        // Key 9 held and acked each time: re-emitted every 3 scans.
        do_reset(16'h0200);
        step(32);
        check("rep_first", 16'(key_valid), 16'h1);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("rep_acked", 16'(key_valid), 16'h0);
        step(46);
        check("rep_before", 16'(key_valid), 16'h0);
        step(1);
        check("rep_second", 16'(key_valid), 16'h1);
        check("rep_code", 16'(key_code), 16'h9);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        step(47);
        check("rep_third", 16'(key_valid), 16'h1);
        check("rep_no_overrun", 16'(ovr_cnt - ovr_base), 16'd0);
`endif

        // Bounce: key 6 on alternate scans never qualifies.
        do_reset(16'h0000);
        for (int s = 1; s <= 6; s++) begin
            pressed = (s % 2 == 1) ? 16'h0040 : 16'h0000;
            step(16);
        end
        check("bounce_valid", 16'(key_valid), 16'h0);
        check("bounce_emits", 16'(rise_cnt - rise_base), 16'd0);

        // Keys 0 and 5 together, then release 5.
        do_reset(16'h0021);
        step(80);
        check("multi_valid", 16'(key_valid), 16'h0);
        pressed = 16'h0001;
        step(31);
        check("multi_rel_before", 16'(key_valid), 16'h0);
        step(1);
        check("multi_rel_valid", 16'(key_valid), 16'h1);
        check("multi_rel_code", 16'(key_code), 16'h0);

        // Overrun: 3 unacked, then C accepted and dropped.
        do_reset(16'h0008);
        step(32);
        check("ovr_k3_valid", 16'(key_valid), 16'h1);
        check("ovr_k3_code", 16'(key_code), 16'h3);
        pressed = 16'h0000;
        step(32);
        pressed = 16'h1000;
        step(32);
        check("ovr_pulse", 16'(overrun), 16'h1);
        check("ovr_code_kept", 16'(key_code), 16'h3);
        check("ovr_valid_kept", 16'(key_valid), 16'h1);
        step(1);
        check("ovr_single", 16'(overrun), 16'h0);
        // Ack in the same cycle as the next emission.
        pressed = 16'h0000;
        step(31);
        pressed = 16'h0400;
        step(31);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("ack_emit_code", 16'(key_code), 16'hA);
        check("ack_emit_valid", 16'(key_valid), 16'h1);
        check("ack_emit_no_ovr", 16'(overrun), 16'h0);
        check("ovr_total", 16'(ovr_cnt - ovr_base), 16'd1);

        // Reset during scan 2 of a press discards the partial debounce.
        do_reset(16'h0200);
        step(20);
        rst = 1'b0;
        #1;
        check("mid_rst_row_sel", 16'(row_sel), 16'hE);
        check("mid_rst_valid", 16'(key_valid), 16'h0);
        check("mid_rst_code", 16'(key_code), 16'h0);
        check("mid_rst_overrun", 16'(overrun), 16'h0);
        step(3);
        rst = 1'b1;
        step(17);
        check("mid_rst_discard", 16'(key_valid), 16'h0);
        step(15);
        check("mid_rst_reaccept", 16'(key_valid), 16'h1);
        check("mid_rst_code9", 16'(key_code), 16'h9);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
